// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage
//
// Writeback stage of the 5-stage RISC-32 pipeline, fed from the MA/WB latch.
// Selects the commit result (call return address, load data or ALU result),
// writes it into the 16 x 32 general register file, serves the two
// operand-fetch read ports, exports a registered copy of the last committed
// write for forwarding, and counts retired instructions.
//
// Ports
//   Clk           pipeline clock, all state updates on posedge
//   Reset         asynchronous, active-high; clears every register
//   in_valid      MA/WB latch holds a real instruction (0 = bubble)
//   stall         hazard unit freezes writeback this cycle
//   Instruction   instruction word, destination field Rd = [25:22]
//   pc_current    PC of the instruction (return address = pc + 4)
//   AluResult     ALU result
//   LdResult      load data
//   IsLd          select load data as the result
//   IsWb          instruction writes a register
//   IsCall        call: writes pc + 4 into the return-address register
//   rd_addr1/2    operand-fetch read addresses
//   rd_data1/2    combinational read data, with same-cycle write bypass
//   fwd_valid     a write committed on the previous edge
//   fwd_addr      destination of that write (held when no write)
//   fwd_data      data of that write (held when no write)
//   retired       number of accepted valid instructions, wraps at 2^32
// ----------------------------------------------------------------------------
module wb_stage #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int RA_IDX = 15
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              in_valid,
   input  logic              stall,
   input  logic [31:0]       Instruction,
   input  logic [DATA_W-1:0] pc_current,
   input  logic [DATA_W-1:0] AluResult,
   input  logic [DATA_W-1:0] LdResult,
   input  logic              IsLd,
   input  logic              IsWb,
   input  logic              IsCall,
   input  logic [3:0]        rd_addr1,
   input  logic [3:0]        rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              fwd_valid,
   output logic [3:0]        fwd_addr,
   output logic [DATA_W-1:0] fwd_data,
   output logic [31:0]       retired
);

   localparam logic [3:0]        RA_ADDR = 4'(RA_IDX);
   localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

   logic [DATA_W-1:0] regs [NREG];

   logic              accept;
   logic              we;
   logic [3:0]        dest;
   logic [DATA_W-1:0] result;

   logic              fwd_valid_q;
   logic [3:0]        fwd_addr_q;
   logic [DATA_W-1:0] fwd_data_q;
   logic [31:0]       retired_q;

   // Only the Rd field of the instruction word matters here.
   logic unused_instr;
   assign unused_instr = ^{Instruction[31:26], Instruction[21:0]};

   // A bubble or a stalled cycle neither writes nor retires; the same inputs
   // are re-presented and commit on the first unstalled edge.
   assign accept = in_valid & ~stall;
   assign we     = accept & (IsWb | IsCall);

   // Call wins over load, load wins over ALU. pc + 4 wraps naturally.
   always_comb begin
      result = AluResult;
      if (IsCall)
         result = pc_current + PC_STEP;
      else if (IsLd)
         result = LdResult;
   end

   assign dest = IsCall ? RA_ADDR : Instruction[25:22];

   // Register 0 is an ordinary register: no hardwired zero.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (we) begin
         regs[dest] <= result;
      end
   end

   // Write-through bypass: operand fetch sees the value being committed this
   // cycle. Each port checks independently, so both may bypass at once.
   always_comb begin
      rd_data1 = regs[rd_addr1];
      if (we && (rd_addr1 == dest))
         rd_data1 = result;
   end

   always_comb begin
      rd_data2 = regs[rd_addr2];
      if (we && (rd_addr2 == dest))
         rd_data2 = result;
   end

   // Forwarding copy: valid for exactly one cycle after a write; address and
   // data keep their last written values otherwise.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fwd_valid_q <= 1'b0;
         fwd_addr_q  <= '0;
         fwd_data_q  <= '0;
      end else begin
         fwd_valid_q <= we;
         if (we) begin
            fwd_addr_q <= dest;
            fwd_data_q <= result;
         end
      end
   end

   // Stores and branches retire too, so the count follows accept, not we.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         retired_q <= '0;
      else if (accept)
         retired_q <= retired_q + 32'd1;
   end

   assign fwd_valid = fwd_valid_q;
   assign fwd_addr  = fwd_addr_q;
   assign fwd_data  = fwd_data_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        in_valid, stall;
   logic [31:0] Instruction, pc_current, AluResult, LdResult;
   logic        IsLd, IsWb, IsCall;
   logic [3:0]  rd_addr1, rd_addr2;
   logic [31:0] rd_data1, rd_data2;
   logic        fwd_valid;
   logic [3:0]  fwd_addr;
   logic [31:0] fwd_data;
   logic [31:0] retired;

   int checks   = 0;
   int failures = 0;

   // Reference model: architectural state as plain arrays and counters.
   logic [31:0] m_regs [16];
   logic [31:0] m_retired;
   logic        m_fwd_valid;
   logic [3:0]  m_fwd_addr;
   logic [31:0] m_fwd_data;

   wb_stage dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .stall(stall),
      .Instruction(Instruction), .pc_current(pc_current),
      .AluResult(AluResult), .LdResult(LdResult),
      .IsLd(IsLd), .IsWb(IsWb), .IsCall(IsCall),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .retired(retired)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] exp_result();
      if (IsCall) return pc_current + 32'd4;
      if (IsLd)   return LdResult;
      return AluResult;
   endfunction

   function automatic logic [3:0] exp_dest();
      return IsCall ? 4'd15 : Instruction[25:22];
   endfunction

   function automatic bit exp_accept();
      return in_valid && !stall;
   endfunction

   function automatic bit exp_we();
      return exp_accept() && (IsWb || IsCall);
   endfunction

   function automatic logic [31:0] exp_read(input logic [3:0] a);
      if (exp_we() && a == exp_dest()) return exp_result();
      return m_regs[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_retired   = '0;
      m_fwd_valid = 1'b0;
      m_fwd_addr  = '0;
      m_fwd_data  = '0;
   endtask

   task automatic set_in(input bit v, input bit s, input logic [3:0] rd,
                         input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] ld, input bit ld_f,
                         input bit wb_f, input bit call_f);
      logic [31:0] ins;
      ins = $urandom;
      ins[25:22] = rd;
      in_valid = v; stall = s; Instruction = ins; pc_current = pc;
      AluResult = alu; LdResult = ld; IsLd = ld_f; IsWb = wb_f; IsCall = call_f;
   endtask

   task automatic idle();
      set_in(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Clock one edge, updating the model from the inputs presented.
   task automatic tick();
      bit          we_e, acc_e;
      logic [3:0]  d_e;
      logic [31:0] r_e;
      we_e = exp_we(); acc_e = exp_accept(); d_e = exp_dest(); r_e = exp_result();
      @(posedge Clk);
      if (we_e) begin
         m_regs[d_e] = r_e;
         m_fwd_addr  = d_e;
         m_fwd_data  = r_e;
      end
      m_fwd_valid = we_e;
      if (acc_e) m_retired = m_retired + 32'd1;
      #1;
   endtask

   task automatic test_reset();
      idle();
      Reset = 1'b1;
      model_reset();
      #3;
      for (int i = 0; i < 16; i++) begin
         rd_addr1 = 4'(i); rd_addr2 = 4'(15 - i);
         #1;
         checks++;
         if (rd_data1 !== 32'd0 || rd_data2 !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs idx=%0d got1=%h got2=%h want=0", i, rd_data1, rd_data2);
         end
      end
      checks++;
      if (retired !== 32'd0 || fwd_valid !== 1'b0 || fwd_addr !== 4'd0 || fwd_data !== 32'd0) begin
         failures++;
         $display("FAIL reset_state retired=%h fwd_valid=%b fwd_addr=%h fwd_data=%h want all 0",
                  retired, fwd_valid, fwd_addr, fwd_data);
      end
      @(negedge Clk);
      Reset = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic test_alu_write();
      set_in(1'b1, 1'b0, 4'd3, 32'h100, 32'h0000_00A5, 32'h1111_1111, 1'b0, 1'b1, 1'b0);
      rd_addr1 = 4'd3; rd_addr2 = 4'd3;
      #1;
      checks++;
      if (rd_data1 !== 32'hA5 || rd_data2 !== 32'hA5) begin
         failures++;
         $display("FAIL alu_bypass got1=%h got2=%h want=000000a5", rd_data1, rd_data2);
      end
      tick();
      idle();
      #1;
      checks++;
      if (fwd_valid !== 1'b1 || fwd_addr !== 4'd3 || fwd_data !== 32'hA5 || retired !== m_retired) begin
         failures++;
         $display("FAIL alu_fwd valid=%b addr=%h data=%h retired=%h want 1/3/a5/%h",
                  fwd_valid, fwd_addr, fwd_data, retired, m_retired);
      end
      tick();
      checks++;
      if (fwd_valid !== 1'b0 || fwd_addr !== 4'd3 || fwd_data !== 32'hA5) begin
         failures++;
         $display("FAIL fwd_hold valid=%b addr=%h data=%h want 0/3/a5", fwd_valid, fwd_addr, fwd_data);
      end
   endtask

   task automatic test_load_select();
      set_in(1'b1, 1'b0, 4'd7, 32'h200, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
      tick();
      idle();
      rd_addr1 = 4'd7;
      #1;
      checks++;
      if (rd_data1 !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL load_select got=%h want=deadbeef", rd_data1);
      end
   endtask

   task automatic test_call();
      logic [31:0] r2_before;
      set_in(1'b1, 1'b0, 4'd2, 32'h0, 32'h2222, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
      r2_before = m_regs[2];
      set_in(1'b1, 1'b0, 4'd15, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 1'b0, 4'd2, 32'hFFFF_FFFC, 32'h3333, 32'h4444, 1'b1, 1'b1, 1'b1);
      tick();
      idle();
      rd_addr1 = 4'd15; rd_addr2 = 4'd2;
      #1;
      checks++;
      if (rd_data1 !== 32'h0 || rd_data2 !== r2_before || fwd_addr !== 4'd15) begin
         failures++;
         $display("FAIL call r15=%h want=0 r2=%h want=%h fwd_addr=%h want=f",
                  rd_data1, rd_data2, r2_before, fwd_addr);
      end
   endtask

   task automatic test_stall_bubble();
      logic [31:0] r5_before, ret_before;
      r5_before  = m_regs[5];
      ret_before = m_retired;
      rd_addr1 = 4'd5; rd_addr2 = 4'd5;
      for (int c = 0; c < 3; c++) begin
         set_in(1'b1, 1'b1, 4'd5, 32'h0, 32'h55, 32'h0, 1'b0, 1'b1, 1'b0);
         tick();
         checks++;
         if (rd_data1 !== r5_before || retired !== ret_before || fwd_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d r5=%h want=%h retired=%h want=%h fwd_valid=%b",
                     c, rd_data1, r5_before, retired, ret_before, fwd_valid);
         end
      end
      stall = 1'b0;
      tick();
      idle();
      #1;
      checks++;
      if (rd_data1 !== 32'h55 || retired !== ret_before + 32'd1) begin
         failures++;
         $display("FAIL stall_release r5=%h want=55 retired=%h want=%h", rd_data1, retired, ret_before + 32'd1);
      end
      set_in(1'b0, 1'b0, 4'd5, 32'h0, 32'h77, 32'h0, 1'b0, 1'b1, 1'b1);
      #1;
      checks++;
      if (rd_data1 !== 32'h55) begin
         failures++;
         $display("FAIL bubble_bypass r5=%h want=55", rd_data1);
      end
      tick();
      checks++;
      if (rd_data1 !== 32'h55 || retired !== ret_before + 32'd1 || fwd_valid !== 1'b0) begin
         failures++;
         $display("FAIL bubble r5=%h want=55 retired=%h want=%h fwd_valid=%b",
                  rd_data1, retired, ret_before + 32'd1, fwd_valid);
      end
   endtask

   task automatic test_async_reset();
      set_in(1'b1, 1'b0, 4'd9, 32'h0, 32'h1234, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
      idle();
      rd_addr1 = 4'd9;
      #1;
      checks++;
      if (rd_data1 !== 32'h1234) begin
         failures++;
         $display("FAIL pre_reset r9=%h want=1234", rd_data1);
      end
      #1;
      Reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (rd_data1 !== 32'h0 || retired !== 32'h0 || fwd_valid !== 1'b0) begin
         failures++;
         $display("FAIL async_reset r9=%h retired=%h fwd_valid=%b want all 0", rd_data1, retired, fwd_valid);
      end
      @(negedge Clk);
      Reset = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic test_retire_wrap();
      idle();
      @(negedge Clk);
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      m_retired = 32'hFFFF_FFFF;
      set_in(1'b1, 1'b0, 4'd1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      checks++;
      if (retired !== 32'h0) begin
         failures++;
         $display("FAIL retire_wrap got=%h want=00000000", retired);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         set_in(($urandom % 4) != 0, ($urandom % 4) == 0, 4'($urandom), $urandom, $urandom,
                $urandom, 1'($urandom), 1'($urandom), ($urandom % 5) == 0);
         // Bias read addresses toward the destination to exercise the bypass.
         rd_addr1 = ($urandom % 3 == 0) ? exp_dest() : 4'($urandom);
         rd_addr2 = ($urandom % 3 == 0) ? exp_dest() : 4'($urandom);
         #1;
         checks++;
         if (rd_data1 !== exp_read(rd_addr1) || rd_data2 !== exp_read(rd_addr2)) begin
            failures++;
            $display("FAIL rand_read n=%0d a1=%h d1=%h want=%h a2=%h d2=%h want=%h",
                     n, rd_addr1, rd_data1, exp_read(rd_addr1), rd_addr2, rd_data2, exp_read(rd_addr2));
         end
         tick();
         checks++;
         if (fwd_valid !== m_fwd_valid || retired !== m_retired ||
             (m_fwd_valid && (fwd_addr !== m_fwd_addr || fwd_data !== m_fwd_data))) begin
            failures++;
            $display("FAIL rand_state n=%0d fwd=%b/%h/%h want=%b/%h/%h retired=%h want=%h",
                     n, fwd_valid, fwd_addr, fwd_data, m_fwd_valid, m_fwd_addr, m_fwd_data,
                     retired, m_retired);
         end
      end
      idle();
      for (int i = 0; i < 16; i++) begin
         rd_addr1 = 4'(i); rd_addr2 = 4'(i);
         #1;
         checks++;
         if (rd_data1 !== m_regs[i] || rd_data2 !== m_regs[i]) begin
            failures++;
            $display("FAIL rand_final idx=%0d got=%h/%h want=%h", i, rd_data1, rd_data2, m_regs[i]);
         end
      end
   endtask

   initial begin
      Reset = 1'b0;
      rd_addr1 = '0; rd_addr2 = '0;
      idle();
      model_reset();
      #2;
      test_reset();
      test_alu_write();
      test_load_select();
      test_call();
      test_stall_bubble();
      test_async_reset();
      test_random();
      test_retire_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 5-stage RISC-32 pipeline, on the consuming side of the MA/WB pipeline register. It selects the result (ALU, load, or return address), writes it into the 16 x 32 general register file, and serves the register-file read ports used by operand fetch. It also exports a registered copy of the last committed write for forwarding and counts retired instructions.

## Interface
- DATA_W, 32, datapath width
- NREG, 16, number of architectural registers (4-bit index)
- RA_IDX, 15, return-address register written by call
- Clk  in  1  pipeline clock; all state updates on posedge
- Reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  MA/WB latch holds a real instruction (0 = bubble)
- stall  in  1  hazard unit freezes writeback this cycle
- Instruction  in  32  instruction word; Rd = Instruction[25:22]
- pc_current  in  32  PC of the instruction
- AluResult  in  32  ALU result from MA/WB
- LdResult  in  32  load data from MA/WB
- IsLd, IsWb, IsCall  in  1 each  control flags from MA/WB
- rd_addr1, rd_addr2  in  4 each  operand-fetch read addresses
- rd_data1, rd_data2  out  32 each  read data (combinational)
- fwd_valid  out  1  registered: a write committed last cycle
- fwd_addr  out  4  registered destination of that write
- fwd_data  out  32  registered data of that write
- retired  out  32  count of accepted valid instructions

## Operation
- Accept condition: accept = in_valid & ~stall.
- Result select (priority): IsCall -> pc_current + 4 (mod 2^32); else IsLd -> LdResult; else AluResult.
- Destination: IsCall -> RA_IDX; else Instruction[25:22].
- Write enable: we = accept & (IsWb | IsCall). On posedge Clk with we, regfile[dest] <= result.
- Register 0 is ordinary (writable); no hardwired zero.
- Read ports: rd_dataN = regfile[rd_addrN], with write-through bypass: if we and rd_addrN == dest, rd_dataN = result in the same cycle. Both ports bypass independently, including when both addresses equal dest.
- Forwarding outputs: on posedge, fwd_valid <= we, fwd_addr <= dest, fwd_data <= result. When we = 0, fwd_valid <= 0 and fwd_addr/fwd_data hold their previous values.
- Retire counter: on posedge with accept, retired <= retired + 1, wrapping 0xFFFFFFFF -> 0. Bubbles and stalled cycles do not count. Stores and branches (IsWb = 0) count.
- Flags set with in_valid = 0 are ignored entirely.

## Timing
- Reset (async, any time): all 16 registers, fwd_valid, fwd_addr, fwd_data and retired go to 0 immediately. rd_data reflects zeroed registers combinationally. A write coinciding with Reset assertion is lost.
- Write latency: the value is in the register file at the posedge. It is visible combinationally on the read ports in the same cycle via bypass.
- Forward latency: fwd_* are valid for exactly one cycle after the write edge.
- Stall held N cycles: no writes and no count. The inputs are re-presented and commit once, on the first unstalled edge.
- Inputs must be stable before posedge (MA/WB updates them on negedge).

## Test plan
- Reset then read all 16 registers -> rd_data1/2 = 0, retired = 0, fwd_valid = 0.
- ALU write: in_valid=1, IsWb=1, Rd=3, AluResult=0x0000_00A5 -> same cycle rd_data1(addr 3) = 0xA5 via bypass; next cycle fwd_valid=1, fwd_addr=3, fwd_data=0xA5, retired=1.
- Load vs ALU select: IsLd=1, LdResult=0xDEAD_BEEF, AluResult=0x10, Rd=7 -> r7 = 0xDEADBEEF.
- Call: IsCall=1, pc_current=0xFFFF_FFFC, Rd field=2 -> r15 = 0x0000_0000, r2 unchanged.
- Stall/bubble: stall=1 for 3 cycles with IsWb=1, Rd=5, AluResult=0x55, then stall=0 -> r5 written once, retired +1 only. A bubble with IsWb=1 writes nothing.
- Async reset mid-run: assert Reset between edges after r9 = 0x1234 -> r9 = 0 and retired = 0 with no clock edge required. Separately, preload retired = 0xFFFFFFFF via 2^32 accepts (or force) -> next accept wraps to 0.
